// File: rtl/serial_mag_comp.sv
// serial_mag_comp: bit-serial cascadable unsigned magnitude comparator.
//
// An operand set (a, b, in) is accepted in IDLE with a valid/ready handshake.
// The pair is then scanned one bit per cycle, MSB first, in SCAN. The result is
// presented in DONE until the downstream stage consumes it.
//
// Ports:
//   clk        clock, rising edge active
//   rst_n      asynchronous active-low reset
//   in_valid   upstream offers a, b, in
//   in_ready   high only in IDLE
//   a, b       unsigned operands, WIDTH bits
//   in         cascade result from the more-significant stage (100 gt, 010 eq, 001 lt)
//   out        comparison result in the same encoding; 000 when out_valid is low
//                or when the captured in was not one-hot
//   out_valid  out holds a final result
//   out_ready  downstream consumes out (only looked at in DONE)
//
// Build option:
//   SERIAL_MAG_COMP_EARLY_EXIT_EN  leave SCAN as soon as the running result is
//                                  decided, instead of always scanning WIDTH bits.
module serial_mag_comp #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       in,
  output logic [2:0]       out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IdxTop = IW'(WIDTH - 1);

  localparam logic [2:0] ResGt = 3'b100;
  localparam logic [2:0] ResEq = 3'b010;
  localparam logic [2:0] ResLt = 3'b001;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       res_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    cyc_q;
  logic             err_q;
  logic [2:0]       out_q;
  logic             out_valid_q;

  logic       bit_a;
  logic       bit_b;
  logic [2:0] res_step;
  logic       scan_last;
  logic       in_onehot;

  // Running result after examining the current bit pair. Once the result has
  // left 010 (decided here or seeded by the cascade) it is frozen.
  always_comb begin
    bit_a    = a_q[idx_q];
    bit_b    = b_q[idx_q];
    res_step = res_q;
    if (res_q == ResEq) begin
      if (bit_a && !bit_b) begin
        res_step = ResGt;
      end else if (!bit_a && bit_b) begin
        res_step = ResLt;
      end
    end
`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
    scan_last = (cyc_q == IdxTop) || (res_step != ResEq);
`else
    scan_last = (cyc_q == IdxTop);
`endif
  end

  assign in_onehot = (in == ResGt) || (in == ResEq) || (in == ResLt);

  assign in_ready  = (state_q == StIdle);
  assign out       = out_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= ResEq;
      idx_q       <= IdxTop;
      cyc_q       <= '0;
      err_q       <= 1'b0;
      out_q       <= 3'b000;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= in;
            err_q   <= !in_onehot;
            idx_q   <= IdxTop;
            cyc_q   <= '0;
            state_q <= StScan;
          end
        end
        StScan: begin
          res_q <= res_step;
          idx_q <= idx_q - 1'b1;
          cyc_q <= cyc_q + 1'b1;
          if (scan_last) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          // First DONE cycle publishes the result; out_valid rises one edge
          // after the last scanned bit.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_q       <= err_q ? 3'b000 : res_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_q       <= 3'b000;
            res_q       <= ResEq;
            idx_q       <= IdxTop;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
module tb_serial_mag_comp;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   cin;
  logic [2:0]   cout;
  logic         out_valid;
  logic         out_ready;

  int total;
  int bad;

  serial_mag_comp #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .in       (cin),
    .out      (cout),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result from the comparison rules.
  function automatic logic [2:0] ref_out(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                         input logic [2:0] rin);
    if (rin == 3'b100 || rin == 3'b001) return rin;
    if (rin != 3'b010) return 3'b000;
    if (ra > rb) return 3'b100;
    if (ra < rb) return 3'b001;
    return 3'b010;
  endfunction

  // Reference latency from transfer edge to out_valid rising.
  function automatic int ref_lat(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                 input logic [2:0] rin);
`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
    int k;
    if (rin != 3'b010) return 2;
    k = 0;
    for (int i = W - 1; i >= 0; i--) begin
      k++;
      if (ra[i] != rb[i]) break;
    end
    return k + 1;
`else
    return W + 1;
`endif
  endfunction

  // Called at posedge+1. Returns at posedge+1 of the edge where out_valid rose.
  task automatic xfer(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [2:0] tin,
                      output int lat, output logic [2:0] got);
    a        = ta;
    b        = tb_v;
    cin      = tin;
    in_valid = 1'b1;
    check("in_ready_before_xfer", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    cin      = 3'($urandom);
    lat      = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = cout;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_after_consume", out_valid, 0);
    check("out_after_consume", cout, 0);
    check("ready_after_consume", in_ready, 1);
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic [2:0] tin);
    int lat;
    logic [2:0] got;
    xfer(ta, tb_v, tin, lat, got);
    check({tag, "_out"}, got, ref_out(ta, tb_v, tin));
    check({tag, "_lat"}, lat, ref_lat(ta, tb_v, tin));
    release_result();
  endtask

  initial begin
    int lat;
    logic [2:0] got;
    logic [2:0] held;
    logic [2:0] rin;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 3'b010;

    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    run_check("gt_0101_0011", 4'b0101, 4'b0011, 3'b010);
    run_check("eq_1010", 4'b1010, 4'b1010, 3'b010);
    run_check("cascade_lt", 4'b1111, 4'b0000, 3'b001);
    run_check("cascade_gt", 4'b0000, 4'b1111, 3'b100);
    run_check("zeros", 4'b0000, 4'b0000, 3'b010);
    run_check("ones", 4'b1111, 4'b1111, 3'b010);
    run_check("err_000", 4'b1000, 4'b0001, 3'b000);
    run_check("err_111", 4'b1000, 4'b0001, 3'b111);

    // Long stall in DONE with in_valid pulses that must be ignored.
    xfer(4'b0110, 4'b1001, 3'b010, lat, got);
    check("stall_first_out", got, 3'b001);
    held = got;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a        = 4'b1111;
      b        = 4'b0000;
      cin      = 3'b100;
      @(posedge clk); #1;
      check("stall_out", cout, held);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_result();
    // No transfer may have been accepted during the stall.
    @(posedge clk); #1;
    check("stall_no_ghost", out_valid, 0);
    check("stall_ready", in_ready, 1);

    // out_ready held high throughout is ignored until DONE.
    out_ready = 1'b1;
    xfer(4'b1100, 4'b1011, 3'b010, lat, got);
    check("rdyhigh_out", got, 3'b100);
    check("rdyhigh_lat", lat, ref_lat(4'b1100, 4'b1011, 3'b010));
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rdyhigh_consumed", out_valid, 0);
    check("rdyhigh_in_ready", in_ready, 1);

    // Reset in the middle of a scan.
    a        = 4'b1111;
    b        = 4'b0000;
    cin      = 3'b010;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_out", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_result", out_valid, 0);
    run_check("after_rst", 4'b0000, 4'b0001, 3'b010);

    // Exhaustive compare with in=010.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_check("exh", 4'(i), 4'(j), 3'b010);
      end
    end

    // Non-one-hot cascade 011 always yields 000.
    for (int i = 0; i < 16; i++) begin
      run_check("err_011", 4'(i), 4'($urandom), 3'b011);
    end

    // Random operands and cascade codes, random stall lengths.
    for (int n = 0; n < 60; n++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      case ($urandom_range(0, 4))
        0: rin = 3'b100;
        1: rin = 3'b001;
        2: rin = 3'($urandom);
        default: rin = 3'b010;
      endcase
      xfer(ra, rb, rin, lat, got);
      check("rand_out", got, ref_out(ra, rb, rin));
      check("rand_lat", lat, ref_lat(ra, rb, rin));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      check("rand_held", cout, ref_out(ra, rb, rin));
      release_result();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_mag_comp.md
SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream offers a, b and in.
REQ-005 SHALL have port in_ready  output  1  block accepts a new operand set.
REQ-006 SHALL have port a  input  WIDTH  first operand, unsigned.
REQ-007 SHALL have port b  input  WIDTH  second operand, unsigned.
REQ-008 SHALL have port in  input  3  cascade result from the more-significant stage, one-hot: 100 gt, 010 eq, 001 lt.
REQ-009 SHALL have port out  output  3  comparison result, same one-hot encoding as in.
REQ-010 SHALL have port out_valid  output  1  out holds a final result.
REQ-011 SHALL have port out_ready  input  1  downstream consumes out.

Function
REQ-012 SHALL implement three states: IDLE, SCAN, DONE.
REQ-013 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid and in_ready are both high at a clock edge.
REQ-014 SHALL, on transfer, capture a, b and in into internal registers, load bit index WIDTH-1, clear the cycle counter, and enter SCAN.
REQ-015 SHALL ignore a, b, in and in_valid outside IDLE; captured values stay stable during SCAN and DONE.
REQ-016 SHALL, in SCAN, examine one bit pair per cycle, MSB first, decrementing the index after each examined bit.
REQ-017 SHALL, while the running result is 010, set it to 100 when a bit is 1 and b bit is 0, and to 001 when a bit is 0 and b bit is 1.
REQ-018 SHALL seed the running result with the captured in; a captured in of 100 or 001 is final and SHALL NOT be changed by any bit pair.
REQ-019 SHALL treat a captured in that is not one-hot as an error: out = 000 in DONE, and the scan sequence and timing are otherwise unchanged.
REQ-020 SHALL move from SCAN to DONE after the bit-0 cycle, with out_valid rising on the following edge; for the baseline build, latency from transfer to out_valid is exactly WIDTH+1 cycles.
REQ-021 SHALL hold out and out_valid = 1 in DONE until out_ready is high at an edge, then return to IDLE with out_valid = 0.
REQ-022 SHALL keep out_ready low in DONE as a stall of unbounded length, with out held constant.
REQ-023 SHALL NOT accept a new transfer on the DONE-to-IDLE edge; the earliest next transfer is one cycle later.
REQ-024 SHALL ignore out_ready outside DONE.
REQ-025 SHALL drive out = 000 whenever out_valid = 0.
REQ-026 SHALL produce results identical to unsigned a>b / a==b / a<b when in = 010, including the all-zeros and all-ones operand boundaries.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force IDLE, in_ready = 1, out_valid = 0, out = 000, index = WIDTH-1, and the running result = 010.
REQ-028 SHALL abort any SCAN or DONE operation on reset mid-operation, with no result delivered.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL compile early termination only when macro SERIAL_MAG_COMP_EARLY_EXIT_EN is defined.
REQ-031 SHALL, with SERIAL_MAG_COMP_EARLY_EXIT_EN defined, leave SCAN on the edge after the running result first becomes non-010 (including a captured in of 100 or 001), giving a latency of k+1 cycles where k is the number of bits examined (k >= 1).
REQ-032 SHALL, without the macro, always take constant latency WIDTH+1 regardless of operands or in.

Verification
REQ-033 SHALL verify (WIDTH=4) a=0101, b=0011, in=010 -> out=100, out_valid rising 5 cycles after transfer (baseline), or 3 cycles with EARLY_EXIT_EN.
REQ-034 SHALL verify a=1010, b=1010, in=010 -> out=010 after 5 cycles in both builds.
REQ-035 SHALL verify a=1111, b=0000, in=001 -> out=001 (cascade wins) after 5 cycles in the baseline build, or 2 cycles with EARLY_EXIT_EN.
REQ-036 SHALL verify out_ready held low for 10 cycles in DONE -> out and out_valid stable; in_ready stays 0; in_valid pulses ignored.
REQ-037 SHALL verify rst_n pulsed low during SCAN -> immediate IDLE, out_valid = 0, out = 000, and a following transfer a=0000, b=0001, in=010 -> out=001.
REQ-038 SHALL verify exhaustive a, b in 0..15 with in=010 against the unsigned compare, and in=011 -> out=000.
